// File: rtl/riscv_branch_predictor_if.sv
// ============================================================================
// Module      : riscv_branch_predictor_if
// Description : Fetch-lookup and EX-resolution bundle for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_branch_predictor_if;
  logic [63:0] i_riscv_bp_fetch_pc;
  logic        o_riscv_bp_pred_taken;
  logic [63:0] o_riscv_bp_pred_target;
  logic        i_riscv_bp_ex_valid;
  logic [63:0] i_riscv_bp_ex_pc;
  logic [63:0] i_riscv_bp_ex_target;
  logic        i_riscv_bp_ex_taken;
  logic        i_riscv_bp_ex_pred_taken;
  logic [63:0] i_riscv_bp_ex_pred_target;
  logic        o_riscv_bp_mispredict;
  logic [63:0] o_riscv_bp_redirect_pc;
  logic [31:0] o_riscv_bp_branch_cnt;
  logic [31:0] o_riscv_bp_mispred_cnt;

  modport master (
    output i_riscv_bp_fetch_pc, i_riscv_bp_ex_valid, i_riscv_bp_ex_pc,
           i_riscv_bp_ex_target, i_riscv_bp_ex_taken, i_riscv_bp_ex_pred_taken,
           i_riscv_bp_ex_pred_target,
    input  o_riscv_bp_pred_taken, o_riscv_bp_pred_target, o_riscv_bp_mispredict,
           o_riscv_bp_redirect_pc, o_riscv_bp_branch_cnt, o_riscv_bp_mispred_cnt
  );

  modport slave (
    input  i_riscv_bp_fetch_pc, i_riscv_bp_ex_valid, i_riscv_bp_ex_pc,
           i_riscv_bp_ex_target, i_riscv_bp_ex_taken, i_riscv_bp_ex_pred_taken,
           i_riscv_bp_ex_pred_target,
    output o_riscv_bp_pred_taken, o_riscv_bp_pred_target, o_riscv_bp_mispredict,
           o_riscv_bp_redirect_pc, o_riscv_bp_branch_cnt, o_riscv_bp_mispred_cnt
  );
endinterface

`default_nettype wire

// File: rtl/riscv_branch_predictor.sv
// ============================================================================
// Module      : riscv_branch_predictor
// Description : Bimodal 2-bit counter table plus tagged BTB, with EX-stage
//               mispredict detection, training and saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAGW    = 10
) (
  input  wire logic                 i_riscv_bp_clk,
  input  wire logic                 i_riscv_bp_rst_n,
  riscv_branch_predictor_if.slave   bp
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGL = IDXW + 2;
  localparam int TAGH = IDXW + TAGW + 1;

  logic [1:0]        cnt_q        [ENTRIES];
  logic [1:0]        cnt_d        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid_q;
  logic [ENTRIES-1:0] btb_valid_d;
  logic [TAGW-1:0]   btb_tag_q    [ENTRIES];
  logic [TAGW-1:0]   btb_tag_d    [ENTRIES];
  logic [63:0]       btb_target_q [ENTRIES];
  logic [63:0]       btb_target_d [ENTRIES];
  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispred_cnt_q, mispred_cnt_d;

  logic [IDXW-1:0]   fetch_idx;
  logic [TAGW-1:0]   fetch_tag;
  logic [IDXW-1:0]   ex_idx;
  logic [TAGW-1:0]   ex_tag;
  logic              fetch_hit;
  logic              fetch_pred_taken;
  logic              mispredict;
  logic              unused_pc_bits;

  assign fetch_idx = bp.i_riscv_bp_fetch_pc[IDXW+1:2];
  assign fetch_tag = bp.i_riscv_bp_fetch_pc[TAGH:TAGL];
  assign ex_idx    = bp.i_riscv_bp_ex_pc[IDXW+1:2];
  assign ex_tag    = bp.i_riscv_bp_ex_pc[TAGH:TAGL];

  assign unused_pc_bits = ^{bp.i_riscv_bp_fetch_pc[63:TAGH+1], bp.i_riscv_bp_fetch_pc[1:0],
                            bp.i_riscv_bp_ex_pc[63:TAGH+1], bp.i_riscv_bp_ex_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign fetch_hit        = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
  assign fetch_pred_taken = fetch_hit && cnt_q[fetch_idx][1];

  assign bp.o_riscv_bp_pred_taken  = fetch_pred_taken;
  assign bp.o_riscv_bp_pred_target = fetch_pred_taken ? btb_target_q[fetch_idx]
                                                       : bp.i_riscv_bp_fetch_pc + 64'd4;

  assign mispredict = bp.i_riscv_bp_ex_valid &&
                      ((bp.i_riscv_bp_ex_taken != bp.i_riscv_bp_ex_pred_taken) ||
                       (bp.i_riscv_bp_ex_taken &&
                        (bp.i_riscv_bp_ex_pred_target != bp.i_riscv_bp_ex_target)));

  assign bp.o_riscv_bp_mispredict  = mispredict;
  assign bp.o_riscv_bp_redirect_pc = !bp.i_riscv_bp_ex_valid ? 64'd0 :
                                     bp.i_riscv_bp_ex_taken  ? bp.i_riscv_bp_ex_target :
                                                               bp.i_riscv_bp_ex_pc + 64'd4;
  assign bp.o_riscv_bp_branch_cnt  = branch_cnt_q;
  assign bp.o_riscv_bp_mispred_cnt = mispred_cnt_q;

  always_comb begin
    cnt_d         = cnt_q;
    btb_valid_d   = btb_valid_q;
    btb_tag_d     = btb_tag_q;
    btb_target_d  = btb_target_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.i_riscv_bp_ex_valid) begin
      if (bp.i_riscv_bp_ex_taken) begin
        if (cnt_q[ex_idx] != 2'd3) cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = ex_tag;
        btb_target_d[ex_idx] = bp.i_riscv_bp_ex_target;
      end else if (cnt_q[ex_idx] != 2'd0) begin
        cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
      end
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge i_riscv_bp_clk or negedge i_riscv_bp_rst_n) begin
    if (!i_riscv_bp_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      btb_valid_q   <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      btb_valid_q   <= btb_valid_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag and target are qualified by btb_valid, so they need no reset.
  always_ff @(posedge i_riscv_bp_clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_branch_predictor.sv
// ============================================================================
// Module      : tb_riscv_branch_predictor
// Description : Randomized bench for riscv_branch_predictor against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int TAGW    = 10;
  localparam int IDXW    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  riscv_branch_predictor_if bp_if ();

  riscv_branch_predictor #(.ENTRIES(ENTRIES), .TAGW(TAGW)) dut (
    .i_riscv_bp_clk   (clk),
    .i_riscv_bp_rst_n (rst_n),
    .bp               (bp_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays indexed by arithmetic on the PC.
  int              m_cnt    [ENTRIES];
  bit              m_valid  [ENTRIES];
  longint unsigned m_tag    [ENTRIES];
  logic [63:0]     m_target [ENTRIES];
  longint unsigned m_branches;
  longint unsigned m_mispreds;

  logic [63:0] pool [8];

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic longint unsigned tag_of(input logic [63:0] pc);
    return (pc >> (IDXW + 2)) % (64'd1 << TAGW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_cnt[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_branches = 0;
    m_mispreds = 0;
  endtask

  task automatic predict(input logic [63:0] pc, output logic pt, output logic [63:0] tgt);
    int i;
    i   = idx_of(pc);
    pt  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
    tgt = pt ? m_target[i] : pc + 64'd4;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the model at posedge.
  task automatic step(input logic [63:0] fpc, input logic ev, input logic [63:0] epc,
                      input logic [63:0] etgt, input logic etk, input logic eptk,
                      input logic [63:0] eptgt);
    logic        exp_pt, exp_mp;
    logic [63:0] exp_tgt, exp_rd;
    int          i;
    @(negedge clk);
    bp_if.i_riscv_bp_fetch_pc       = fpc;
    bp_if.i_riscv_bp_ex_valid       = ev;
    bp_if.i_riscv_bp_ex_pc          = epc;
    bp_if.i_riscv_bp_ex_target      = etgt;
    bp_if.i_riscv_bp_ex_taken       = etk;
    bp_if.i_riscv_bp_ex_pred_taken  = eptk;
    bp_if.i_riscv_bp_ex_pred_target = eptgt;
    #1;
    predict(fpc, exp_pt, exp_tgt);
    exp_mp = ev && ((etk != eptk) || (etk && (eptgt != etgt)));
    exp_rd = !ev ? 64'd0 : (etk ? etgt : epc + 64'd4);
    check("pred_taken",  {63'd0, bp_if.o_riscv_bp_pred_taken}, {63'd0, exp_pt});
    check("pred_target", bp_if.o_riscv_bp_pred_target, exp_tgt);
    check("mispredict",  {63'd0, bp_if.o_riscv_bp_mispredict}, {63'd0, exp_mp});
    check("redirect_pc", bp_if.o_riscv_bp_redirect_pc, exp_rd);
    check("branch_cnt",  {32'd0, bp_if.o_riscv_bp_branch_cnt}, m_branches);
    check("mispred_cnt", {32'd0, bp_if.o_riscv_bp_mispred_cnt}, m_mispreds);
    @(posedge clk);
    if (ev) begin
      i = idx_of(epc);
      if (etk) begin
        m_cnt[i]    = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(epc);
        m_target[i] = etgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
      if (m_branches < 64'hFFFF_FFFF) m_branches++;
      if (exp_mp && m_mispreds < 64'hFFFF_FFFF) m_mispreds++;
    end
  endtask

  task automatic fetch(input logic [63:0] fpc);
    step(fpc, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic train(input logic [63:0] fpc, input logic [63:0] epc, input logic [63:0] etgt,
                       input logic etk, input logic eptk, input logic [63:0] eptgt);
    step(fpc, 1'b1, epc, etgt, etk, eptk, eptgt);
  endtask

  // Reset pulse between clock edges; the cleared state must show before the next edge.
  task automatic mid_reset(input logic [63:0] fpc);
    @(negedge clk);
    bp_if.i_riscv_bp_fetch_pc = fpc;
    bp_if.i_riscv_bp_ex_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pred_taken",  {63'd0, bp_if.o_riscv_bp_pred_taken}, 64'd0);
    check("rst_pred_target", bp_if.o_riscv_bp_pred_target, fpc + 64'd4);
    check("rst_branch_cnt",  {32'd0, bp_if.o_riscv_bp_branch_cnt}, 64'd0);
    check("rst_mispred_cnt", {32'd0, bp_if.o_riscv_bp_mispred_cnt}, 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic        pt;
    logic [63:0] ptgt, epc, etgt, fpc;
    logic        etk, eptk;

    pool[0] = 64'h1000;  pool[1] = 64'h1100;  pool[2] = 64'h2000;  pool[3] = 64'h2004;
    pool[4] = 64'h3008;  pool[5] = 64'h1004;  pool[6] = 64'hFFFF_FFFF_FFFF_FFFC;
    pool[7] = 64'h0000_0000_0004_1000;
    model_reset();

    bp_if.i_riscv_bp_fetch_pc       = 64'h1000;
    bp_if.i_riscv_bp_ex_valid       = 1'b0;
    bp_if.i_riscv_bp_ex_pc          = 64'd0;
    bp_if.i_riscv_bp_ex_target      = 64'd0;
    bp_if.i_riscv_bp_ex_taken       = 1'b0;
    bp_if.i_riscv_bp_ex_pred_taken  = 1'b0;
    bp_if.i_riscv_bp_ex_pred_target = 64'd0;
    #3;
    check("reset_pred_taken",  {63'd0, bp_if.o_riscv_bp_pred_taken}, 64'd0);
    check("reset_pred_target", bp_if.o_riscv_bp_pred_target, 64'h1004);
    check("reset_branch_cnt",  {32'd0, bp_if.o_riscv_bp_branch_cnt}, 64'd0);
    check("reset_mispred_cnt", {32'd0, bp_if.o_riscv_bp_mispred_cnt}, 64'd0);
    #9 rst_n = 1'b1;

    // Cold taken, then hysteresis down through cnt 3 -> 0.
    train(64'h1000, 64'h1000, 64'h0F00, 1'b1, 1'b0, 64'd0);
    fetch(64'h1000);
    check("cold_hit_target", bp_if.o_riscv_bp_pred_target, 64'h0F00);
    for (int k = 0; k < 3; k++) train(64'h1000, 64'h1000, 64'h0F00, 1'b1, 1'b1, 64'h0F00);
    train(64'h1000, 64'h1000, 64'h0F00, 1'b0, 1'b1, 64'h0F00);
    fetch(64'h1000);
    train(64'h1000, 64'h1000, 64'h0F00, 1'b0, 1'b1, 64'h0F00);
    fetch(64'h1000);
    train(64'h2000, 64'h1000, 64'h0F00, 1'b0, 1'b1, 64'h0F00);
    check("nt_redirect", bp_if.o_riscv_bp_redirect_pc, 64'h1004);

    // Aliasing on the same index with a different tag.
    fetch(64'h1100);

    // Same-cycle fetch and train: cnt 0 -> 1, then 1 -> 2 while fetching.
    train(64'h2000, 64'h1000, 64'h0F00, 1'b1, 1'b0, 64'd0);
    train(64'h1000, 64'h1000, 64'h0F00, 1'b1, 1'b0, 64'd0);
    fetch(64'h1000);

    // PC+4 wraparound.
    fetch(64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset after training, then the first post-reset resolution.
    mid_reset(64'h1000);
    train(64'h1000, 64'h1000, 64'h0F00, 1'b1, 1'b0, 64'd0);
    fetch(64'h1000);

    // Randomized traffic over a small PC pool to force hits, aliasing and saturation.
    for (int n = 0; n < 600; n++) begin
      fpc  = pool[$urandom_range(0, 7)];
      epc  = pool[$urandom_range(0, 7)];
      etgt = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} & ~64'd3
                                         : pool[$urandom_range(0, 7)];
      etk  = 1'($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin
        predict(epc, pt, ptgt);
        eptk = pt;
      end else begin
        eptk = 1'($urandom_range(0, 1));
        ptgt = pool[$urandom_range(0, 7)];
      end
      if ($urandom_range(0, 99) == 0) mid_reset(fpc);
      else step(fpc, 1'($urandom_range(0, 3) != 0), epc, etgt, etk, eptk, ptgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_branch_predictor.md
# riscv_branch_predictor

Dynamic branch predictor spanning fetch and execute. Fetch side: a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB) gives a taken/not-taken prediction and a target for the current fetch PC. Execute side: consumes the resolved outcome from the branch comparator, raises a same-cycle mispredict/redirect to the hazard unit, trains the tables on the next clock edge, and keeps saturating performance counters.

## Interface
Parameters:
- ENTRIES, 64, number of table entries; power of two. IDXW = log2(ENTRIES).
- TAGW, 10, BTB tag width.

Ports:
- i_riscv_bp_clk  in  1  clock; all state updates on the rising edge.
- i_riscv_bp_rst_n  in  1  reset; asynchronous, active-low.
- i_riscv_bp_fetch_pc  in  64  PC being fetched.
- o_riscv_bp_pred_taken  out  1  prediction for fetch_pc.
- o_riscv_bp_pred_target  out  64  predicted next PC.
- i_riscv_bp_ex_valid  in  1  conditional branch resolved in EX this cycle (comparator enable, already gated by flush/stall).
- i_riscv_bp_ex_pc  in  64  PC of the EX branch.
- i_riscv_bp_ex_target  in  64  computed branch target.
- i_riscv_bp_ex_taken  in  1  branch-taken output of the comparator.
- i_riscv_bp_ex_pred_taken  in  1  prediction carried down the pipeline.
- i_riscv_bp_ex_pred_target  in  64  predicted target carried down the pipeline.
- o_riscv_bp_mispredict  out  1  flush request.
- o_riscv_bp_redirect_pc  out  64  correct next PC.
- o_riscv_bp_branch_cnt  out  32  resolved-branch count.
- o_riscv_bp_mispred_cnt  out  32  misprediction count.

## Operation
- Index is pc[IDXW+1:2]. Tag is pc[IDXW+TAGW+1:IDXW+2].
- Per entry:
  - cnt[1:0], reset value 2'b01 (weakly not-taken).
  - btb_valid, reset value 0.
  - btb_tag.
  - btb_target (64 bits).
- Lookup (combinational from registered state):
  - hit = btb_valid && tag match.
  - pred_taken = hit && cnt[1].
  - pred_target = pred_taken ? btb_target : fetch_pc + 4.
- Resolution (combinational, only when ex_valid):
  - mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4.
  - Both outputs are 0 when ex_valid is low.
- Training on the clock edge when ex_valid, at the index of ex_pc:
  - Taken: cnt increments, saturating at 3. btb_valid, btb_tag and btb_target are written.
  - Not taken: cnt decrements, saturating at 0. The BTB entry is left unchanged.
- Counters:
  - branch_cnt increments on each ex_valid cycle.
  - mispred_cnt increments on each cycle where mispredict is high.
  - Both saturate at 32'hFFFF_FFFF with no wrap.
- PC+4 arithmetic is 64-bit modulo 2^64: fetch_pc 0xFFFF_FFFF_FFFF_FFFC gives 0.

## Timing
- Lookup and resolution are zero-latency combinational paths.
- Training is visible to lookups one cycle after the ex_valid cycle.
- Fetch and update to the same index in the same cycle: the fetch sees the old state. There is no bypass.
- A stalled EX presents ex_valid only in its final cycle, so each branch trains exactly once.
- Reset asserted at any time, including mid-operation:
  - Immediately, without waiting for a clock edge: all btb_valid clear, all cnt go to 01, both perf counters go to 0.
  - The combinational outputs follow from the cleared state, so pred_taken = 0.
- After reset deasserts: training resumes on the first edge with ex_valid.

## Test plan
- Reset: rst_n low, then fetch_pc=0x1000 -> pred_taken=0, pred_target=0x1004, both counts=0.
- Cold taken:
  - Stimulus: ex_valid, ex_pc=0x1000, ex_target=0x0F00, ex_taken=1, ex_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x0F00, both counts=1 after the edge.
  - Next cycle: fetch 0x1000 -> pred_taken=1, pred_target=0x0F00.
- Hysteresis:
  - Drive three more taken resolutions for 0x1000 (cnt=3), then one not-taken -> fetch still predicts taken.
  - A second not-taken -> pred_taken=0.
  - A not-taken resolution with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x1004.
- Aliasing: after training 0x1000, fetch_pc=0x1100 (same index, tag 0x11 vs 0x10) -> pred_taken=0, pred_target=0x1104.
- Collision/ordering: in the same cycle, fetch 0x1000 while training 0x1000 from cnt=1 to 2 -> pred_taken=0 that cycle, 1 the next.
- Async reset mid-training: drop rst_n between edges after training 0x1000 -> pred_taken=0 before the next edge; counts=0; first post-reset resolution yields branch_cnt=1.
